nios_frame_tx: RTL and testbench

- Transmit end of the Nios parameter byte-stream protocol (En / Sync / 8-bit Data) consumed by the parameter and DAC decoders in the Medipix bridge.
- Host logic fills a payload buffer, supplies a command byte and length, then pulses start.
- The block emits one framed burst: header, payload, optional XOR checksum, then a mandatory idle gap.
- Lets firmware and the testbench drive the bridge with frames that are correct by construction.

---
 rtl/nios_stream_pkg.sv | 37 +++
 rtl/nios_frame_tx_buf.sv | 32 +++
 rtl/nios_frame_tx.sv | 216 +++++++++++++++++++++
 tb/tb_nios_frame_tx.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_stream_pkg.sv
// Shared definitions for the Nios parameter byte-stream (En / Sync / Data).
// Used by the frame transmitter and by the decoder-side bench models.
package nios_stream_pkg;

  // Width of one stream byte.
  localparam int BYTE_W = 8;

  // Transmitter frame sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_PAY  = 3'd2,
    ST_CSUM = 3'd3,
    ST_GAP  = 3'd4
  } tx_state_e;

  // Ceiling log2, usable in constant expressions.
  // A result of 0 is returned for values of 0 or 1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // One step of the running XOR frame checksum.
  function automatic logic [BYTE_W-1:0] csum_step(input logic [BYTE_W-1:0] acc,
                                                  input logic [BYTE_W-1:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/nios_frame_tx_buf.sv
// Payload buffer for the frame transmitter: simple dual-port RAM,
// synchronous write, registered read with one cycle of latency.
// No reset on the array or read register so it maps onto block RAM.
module nios_frame_tx_buf
  import nios_stream_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [BYTE_W-1:0] rd_data
);

  logic [BYTE_W-1:0] mem [DEPTH];

  // Write port: store a byte when the host write is allowed through.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port: always reading, data appears the cycle after the address.
  always_ff @(posedge clk) begin
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/nios_frame_tx.sv
// Nios byte-stream frame transmitter.
// Emits header (Sync marked), payload from the buffer, optional XOR
// checksum, then a fixed idle gap. Payload bytes come straight out of the
// buffer's read register; header/checksum/idle bytes come from data_r.
module nios_frame_tx
  import nios_stream_pkg::*;
#(
  parameter  int MAX_BYTES   = 64,
  parameter  int GAP_CYCLES  = 4,
  parameter  int CHECKSUM_EN = 1,
  localparam int AW_RAW      = clog2(MAX_BYTES),
  localparam int AW          = (AW_RAW > 0) ? AW_RAW : 1,
  localparam int LW          = clog2(MAX_BYTES + 1)
) (
  input  logic              In_Clk_nios,
  input  logic              In_Reset,
  input  logic              In_Wr_En,
  input  logic [AW-1:0]     In_Wr_Addr,
  input  logic [BYTE_W-1:0] In_Wr_Data,
  input  logic [BYTE_W-1:0] In_Cmd,
  input  logic [LW-1:0]     In_Len,
  input  logic              In_Start,
  input  logic              In_Abort,
  output logic              Out_En_nios,
  output logic              Out_Sync_nios,
  output logic [BYTE_W-1:0] Out_Data_nios,
  output logic              Out_Busy,
  output logic              Out_Done,
  output logic              Out_Err
);

  localparam int GW_RAW = clog2(GAP_CYCLES + 1);
  localparam int GW     = (GW_RAW > 0) ? GW_RAW : 1;

  localparam logic [LW-1:0]     MAX_LEN   = LW'(MAX_BYTES);
  localparam logic [LW-1:0]     LEN_ZERO  = {LW{1'b0}};
  localparam logic [LW-1:0]     IDX_ONE   = LW'(1);
  localparam logic [GW-1:0]     GAP_LOAD  = GW'(GAP_CYCLES);
  localparam logic [GW-1:0]     GAP_ONE   = GW'(1);
  localparam logic [BYTE_W-1:0] BYTE_ZERO = {BYTE_W{1'b0}};

  tx_state_e         state_r;
  logic [LW-1:0]     len_r;
  logic [LW-1:0]     idx_r;      // next payload index to fetch (one ahead)
  logic [GW-1:0]     gap_r;
  logic [BYTE_W-1:0] csum_r;
  logic              en_r;
  logic              sync_r;
  logic [BYTE_W-1:0] data_r;
  logic              pay_sel_r;  // stream byte comes from the buffer
  logic              busy_r;
  logic              done_r;
  logic              err_r;

  logic              wr_ok_s;
  logic [AW-1:0]     rd_addr_s;
  logic [BYTE_W-1:0] rd_data_s;

  // Writes are only let through while no frame is in flight, so a frame's
  // contents cannot change under it.
  assign wr_ok_s = In_Wr_En & ~busy_r;

  // Read address follows the prefetch index; past the last slot it parks at 0.
  always_comb begin
    rd_addr_s = {AW{1'b0}};
    if (idx_r < MAX_LEN) begin
      rd_addr_s = idx_r[AW-1:0];
    end else begin
      rd_addr_s = {AW{1'b0}};
    end
  end

  nios_frame_tx_buf #(
    .DEPTH (MAX_BYTES),
    .AW    (AW)
  ) u_buf (
    .clk     (In_Clk_nios),
    .wr_en   (wr_ok_s),
    .wr_addr (In_Wr_Addr),
    .wr_data (In_Wr_Data),
    .rd_addr (rd_addr_s),
    .rd_data (rd_data_s)
  );

  // Frame sequencer: state, counters, checksum and all registered outputs.
  always_ff @(posedge In_Clk_nios or negedge In_Reset) begin
    if (!In_Reset) begin
      state_r   <= ST_IDLE;
      len_r     <= LEN_ZERO;
      idx_r     <= LEN_ZERO;
      gap_r     <= {GW{1'b0}};
      csum_r    <= BYTE_ZERO;
      en_r      <= 1'b0;
      sync_r    <= 1'b0;
      data_r    <= BYTE_ZERO;
      pay_sel_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= In_Wr_En & busy_r;
      case (state_r)
        ST_IDLE: begin
          en_r      <= 1'b0;
          sync_r    <= 1'b0;
          data_r    <= BYTE_ZERO;
          pay_sel_r <= 1'b0;
          busy_r    <= 1'b0;
          if (In_Start) begin
            if (In_Len <= MAX_LEN) begin
              state_r <= ST_HDR;
              en_r    <= 1'b1;
              sync_r  <= 1'b1;
              data_r  <= In_Cmd;
              busy_r  <= 1'b1;
              len_r   <= In_Len;
              csum_r  <= In_Cmd;
              idx_r   <= LEN_ZERO;
            end else begin
              err_r <= 1'b1;
            end
          end
        end

        ST_HDR: begin
          sync_r <= 1'b0;
          if (In_Abort) begin
            state_r <= ST_GAP;
            en_r    <= 1'b0;
            data_r  <= BYTE_ZERO;
            gap_r   <= GAP_LOAD;
          end else if (len_r != LEN_ZERO) begin
            state_r   <= ST_PAY;
            pay_sel_r <= 1'b1;
            data_r    <= BYTE_ZERO;
            idx_r     <= IDX_ONE;
          end else if (CHECKSUM_EN != 0) begin
            state_r <= ST_CSUM;
            data_r  <= csum_r;
          end else begin
            state_r <= ST_GAP;
            en_r    <= 1'b0;
            data_r  <= BYTE_ZERO;
            gap_r   <= GAP_LOAD;
            done_r  <= 1'b1;
          end
        end

        ST_PAY: begin
          // The byte on the stream this cycle is rd_data_s; fold it in.
          csum_r <= csum_step(csum_r, rd_data_s);
          if (In_Abort) begin
            state_r   <= ST_GAP;
            en_r      <= 1'b0;
            pay_sel_r <= 1'b0;
            data_r    <= BYTE_ZERO;
            gap_r     <= GAP_LOAD;
          end else if (idx_r == len_r) begin
            pay_sel_r <= 1'b0;
            if (CHECKSUM_EN != 0) begin
              state_r <= ST_CSUM;
              data_r  <= csum_step(csum_r, rd_data_s);
            end else begin
              state_r <= ST_GAP;
              en_r    <= 1'b0;
              data_r  <= BYTE_ZERO;
              gap_r   <= GAP_LOAD;
              done_r  <= 1'b1;
            end
          end else begin
            idx_r <= idx_r + IDX_ONE;
          end
        end

        ST_CSUM: begin
          state_r <= ST_GAP;
          en_r    <= 1'b0;
          data_r  <= BYTE_ZERO;
          gap_r   <= GAP_LOAD;
          done_r  <= ~In_Abort;
        end

        ST_GAP: begin
          en_r      <= 1'b0;
          sync_r    <= 1'b0;
          data_r    <= BYTE_ZERO;
          pay_sel_r <= 1'b0;
          if (gap_r <= GAP_ONE) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            gap_r <= gap_r - GAP_ONE;
          end
        end

        default: begin
          state_r   <= ST_IDLE;
          en_r      <= 1'b0;
          sync_r    <= 1'b0;
          data_r    <= BYTE_ZERO;
          pay_sel_r <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign Out_En_nios   = en_r;
  assign Out_Sync_nios = sync_r;
  assign Out_Data_nios = pay_sel_r ? rd_data_s : data_r;
  assign Out_Busy      = busy_r;
  assign Out_Done      = done_r;
  assign Out_Err       = err_r;

endmodule

// File: tb/tb_nios_frame_tx.sv
// Bench for nios_frame_tx: two instances (checksum on / off) share stimulus.
// A per-cycle expectation table, filled from the frame rules when stimulus is
// applied, is compared against both instances on every falling edge.
module tb_nios_frame_tx;

  localparam int MAXB = 64;
  localparam int G    = 4;
  localparam int N    = 1024;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [5:0] wr_addr = 6'd0;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] cmd = 8'h00;
  logic [6:0] len = 7'd0;
  logic       start = 1'b0;
  logic       abort = 1'b0;

  logic       en0, sync0, busy0, done0, err0;
  logic       en1, sync1, busy1, done1, err1;
  logic [7:0] data0, data1;

  bit         x_en   [2][N];
  bit         x_sync [2][N];
  bit         x_busy [2][N];
  bit         x_done [2][N];
  bit         x_err  [2][N];
  bit [7:0]   x_data [2][N];
  bit [7:0]   sh     [2][MAXB];

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nios_frame_tx #(.MAX_BYTES(MAXB), .GAP_CYCLES(G), .CHECKSUM_EN(1)) dut0 (
    .In_Clk_nios(clk), .In_Reset(rst_n), .In_Wr_En(wr_en), .In_Wr_Addr(wr_addr),
    .In_Wr_Data(wr_data), .In_Cmd(cmd), .In_Len(len), .In_Start(start), .In_Abort(abort),
    .Out_En_nios(en0), .Out_Sync_nios(sync0), .Out_Data_nios(data0),
    .Out_Busy(busy0), .Out_Done(done0), .Out_Err(err0));

  nios_frame_tx #(.MAX_BYTES(MAXB), .GAP_CYCLES(G), .CHECKSUM_EN(0)) dut1 (
    .In_Clk_nios(clk), .In_Reset(rst_n), .In_Wr_En(wr_en), .In_Wr_Addr(wr_addr),
    .In_Wr_Data(wr_data), .In_Cmd(cmd), .In_Len(len), .In_Start(start), .In_Abort(abort),
    .Out_En_nios(en1), .Out_Sync_nios(sync1), .Out_Data_nios(data1),
    .Out_Busy(busy1), .Out_Done(done1), .Out_Err(err1));

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison of both instances against the expectation table.
  always @(negedge clk) begin
    if (cyc < N) begin
      chk("flags0", {3'b000, en0, sync0, busy0, done0, err0},
          {3'b000, x_en[0][cyc], x_sync[0][cyc], x_busy[0][cyc], x_done[0][cyc], x_err[0][cyc]});
      chk("data0", data0, x_data[0][cyc]);
      chk("flags1", {3'b000, en1, sync1, busy1, done1, err1},
          {3'b000, x_en[1][cyc], x_sync[1][cyc], x_busy[1][cyc], x_done[1][cyc], x_err[1][cyc]});
      chk("data1", data1, x_data[1][cyc]);
    end
  end

  task automatic clear_from(input int d, input int c, input bit with_err);
    for (int k = c; k < c + 100 && k < N; k++) begin
      x_en[d][k] = 1'b0; x_sync[d][k] = 1'b0; x_busy[d][k] = 1'b0;
      x_done[d][k] = 1'b0; x_data[d][k] = 8'h00;
      if (with_err) x_err[d][k] = 1'b0;
    end
  endtask

  // Whole-frame expectation for an accepted start in cycle t.
  task automatic fill(input int d, input int t, input logic [7:0] c_cmd, input int l);
    int c;
    logic [7:0] x;
    clear_from(d, t + 1, 1'b0);
    c = t + 1;
    x = c_cmd;
    x_en[d][c] = 1'b1; x_sync[d][c] = 1'b1; x_data[d][c] = c_cmd;
    for (int i = 0; i < l; i++) begin
      c++;
      x_en[d][c] = 1'b1; x_data[d][c] = sh[d][i];
      x = x ^ sh[d][i];
    end
    if (d == 0) begin
      c++;
      x_en[d][c] = 1'b1; x_data[d][c] = x;
    end
    x_done[d][c + 1] = 1'b1;
    for (int k = t + 1; k <= c + G; k++) x_busy[d][k] = 1'b1;
  endtask

  // Abort in cycle c: stream stops, full gap follows.
  task automatic cut(input int d, input int c);
    clear_from(d, c + 1, 1'b0);
    for (int k = c + 1; k <= c + G; k++) x_busy[d][k] = 1'b1;
  endtask

  task automatic drive(input bit st, input logic [7:0] cm, input int ln,
                       input bit we, input int wa, input logic [7:0] wd, input bit ab);
    @(posedge clk);
    cyc++;
    #1;
    start = st; cmd = cm; len = 7'(ln); wr_en = we; wr_addr = 6'(wa); wr_data = wd; abort = ab;
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        if (we) begin
          if (x_busy[d][cyc]) x_err[d][cyc + 1] = 1'b1;
          else sh[d][wa] = wd;
        end
        if (st && !x_busy[d][cyc]) begin
          if (ln > MAXB) x_err[d][cyc + 1] = 1'b1;
          else fill(d, cyc, cm, ln);
        end else if (ab && x_en[d][cyc]) begin
          cut(d, cyc);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00, 0, 1'b0, 0, 8'h00, 1'b0);
  endtask

  initial begin
    // Reset held for a few cycles.
    idle(3);
    #2;
    chk("rst_flags", {3'b000, en0, sync0, busy0, done0, err0}, 8'h00);
    rst_n = 1'b1;
    idle(2);

    // Basic frame: Cmd A5, payload 01 02 04, checksum A2.
    drive(1'b0, 8'h00, 0, 1'b1, 0, 8'h01, 1'b0);
    drive(1'b0, 8'h00, 0, 1'b1, 1, 8'h02, 1'b0);
    drive(1'b0, 8'h00, 0, 1'b1, 2, 8'h04, 1'b0);
    drive(1'b1, 8'hA5, 3, 1'b0, 0, 8'h00, 1'b0);
    for (int k = 1; k <= 11; k++) begin
      idle(1);
      #3;
      if (k == 1) begin
        chk("t1_sync", {7'd0, sync0}, 8'd1);
        chk("t1_cmd", data0, 8'hA5);
      end
      if (k == 3) chk("t1_pay1", data0, 8'h02);
      if (k == 5) chk("t1_csum", data0, 8'hA2);
      if (k == 5) chk("t1_done_nocs", {7'd0, done1}, 8'd1);
      if (k == 6) chk("t1_done", {7'd0, done0}, 8'd1);
      if (k == 9) chk("t1_busy9", {7'd0, busy0}, 8'd1);
      if (k == 10) chk("t1_busy10", {7'd0, busy0}, 8'd0);
    end

    // Empty payload.
    drive(1'b1, 8'h3C, 0, 1'b0, 0, 8'h00, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      idle(1);
      #3;
      if (k == 2) begin
        chk("len0_csum", data0, 8'h3C);
        chk("len0_en", {7'd0, en0}, 8'd1);
        chk("len0_done_nocs", {7'd0, done1}, 8'd1);
      end
    end

    // Full-length frame, buf[i] = i.
    for (int i = 0; i < MAXB; i++) drive(1'b0, 8'h00, 0, 1'b1, i, 8'(i), 1'b0);
    drive(1'b1, 8'h5A, MAXB, 1'b0, 0, 8'h00, 1'b0);
    for (int k = 1; k <= 72; k++) begin
      idle(1);
      #3;
      if (k == 65) chk("full_last", data0, 8'h3F);
      if (k == 66) chk("full_csum", data0, 8'h5A);
    end
    drive(1'b1, 8'h11, MAXB + 1, 1'b0, 0, 8'h00, 1'b0);
    idle(1);
    #3;
    chk("len65_err", {6'd0, err1, err0}, 8'h03);
    chk("len65_en", {7'd0, en0}, 8'd0);
    idle(2);

    // Start and writes while busy.
    drive(1'b0, 8'h00, 0, 1'b1, 0, 8'h11, 1'b0);
    drive(1'b0, 8'h00, 0, 1'b1, 1, 8'h22, 1'b0);
    drive(1'b0, 8'h00, 0, 1'b1, 2, 8'h33, 1'b0);
    drive(1'b1, 8'h10, 3, 1'b0, 0, 8'h00, 1'b0);
    drive(1'b1, 8'h99, 1, 1'b1, 0, 8'hFF, 1'b0);
    drive(1'b0, 8'h00, 0, 1'b1, 1, 8'hEE, 1'b0);
    #3;
    chk("busy_wr_err", {7'd0, err0}, 8'd1);
    idle(12);
    drive(1'b1, 8'h10, 3, 1'b0, 0, 8'h00, 1'b0);
    for (int k = 1; k <= 11; k++) begin
      idle(1);
      #3;
      if (k == 2) chk("frozen_b0", data0, 8'h11);
      if (k == 5) chk("frozen_csum", data0, 8'h10);
    end

    // Abort on the second payload byte.
    drive(1'b1, 8'h77, 5, 1'b0, 0, 8'h00, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      drive(1'b0, 8'h00, 0, 1'b0, 0, 8'h00, k == 3);
      #3;
      if (k == 3) chk("abort_b1", data0, 8'h22);
      if (k == 4) chk("abort_en", {7'd0, en0}, 8'd0);
      if (k == 7) chk("abort_busy7", {7'd0, busy0}, 8'd1);
      if (k == 8) chk("abort_busy8", {7'd0, busy0}, 8'd0);
    end

    // Start and abort together in IDLE: start wins.
    drive(1'b1, 8'h42, 1, 1'b0, 0, 8'h00, 1'b1);
    idle(1);
    #3;
    chk("start_abort_en", {7'd0, en0}, 8'd1);
    idle(10);

    // Reset in the middle of the payload.
    drive(1'b1, 8'hC0, 3, 1'b0, 0, 8'h00, 1'b0);
    idle(3);
    #2;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) clear_from(d, cyc, 1'b1);
    #1;
    chk("mid_rst0", {3'b000, en0, sync0, busy0, done0, err0}, 8'h00);
    chk("mid_rst_d0", data0, 8'h00);
    chk("mid_rst1", {3'b000, en1, sync1, busy1, done1, err1}, 8'h00);
    idle(2);
    rst_n = 1'b1;
    drive(1'b1, 8'hC3, 2, 1'b0, 0, 8'h00, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      idle(1);
      #3;
      if (k == 1) chk("post_rst_hdr", data0, 8'hC3);
      if (k == 3) chk("post_rst_b1", data0, 8'h22);
      if (k == 4) chk("post_rst_csum", data0, 8'hF0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
